// File: rtl/qam_nibble_packer_pkg.sv
// Shared constants for the 16QAM nibble packer: symbol width, FSM encoding,
// and word-counter width.
package qam_pkg;
  localparam int SYMBOL_W = 4;
  localparam int WC_W     = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;
endpackage

// File: rtl/qam_nibble_packer_if.sv
// FIFO read side plus packed-word valid/ready bus of the nibble packer.
// QAM_PACKER_PARITY_EN adds out_parity alongside out_data.
interface qam_nibble_packer_if #(parameter int NIBBLES_PER_WORD = 2);
  import qam_pkg::*;

  logic                                 rdempty;
  logic [SYMBOL_W-1:0]                  q;
  logic                                 rdreq;
  logic [SYMBOL_W*NIBBLES_PER_WORD-1:0] out_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_partial;
`ifdef QAM_PACKER_PARITY_EN
  logic                                 out_parity;

  modport master (input rdempty, q, out_ready,
                  output rdreq, out_data, out_valid, out_partial, out_parity);
  modport slave  (output rdempty, q, out_ready,
                  input rdreq, out_data, out_valid, out_partial, out_parity);
`else
  modport master (input rdempty, q, out_ready,
                  output rdreq, out_data, out_valid, out_partial);
  modport slave  (output rdempty, q, out_ready,
                  input rdreq, out_data, out_valid, out_partial);
`endif
endinterface

// File: rtl/qam_nibble_packer_shift_slot.sv
// Shadow word with a fill counter: writes the incoming nibble into the next
// slot (MSN- or LSN-first) and clears back to all-zero.
module qam_nibble_shift_slot
  import qam_pkg::*;
#(
  parameter int NIBBLES_PER_WORD = 2,
  parameter bit MSN_FIRST        = 1'b1,
  parameter int SW               = $clog2(NIBBLES_PER_WORD + 1)
) (
  input  logic                                 dclk,
  input  logic                                 reset,
  input  logic                                 i_wr,
  input  logic                                 i_clr,
  input  logic [SYMBOL_W-1:0]                  i_nib,
  output logic [SYMBOL_W*NIBBLES_PER_WORD-1:0] o_word,
  output logic [SYMBOL_W*NIBBLES_PER_WORD-1:0] o_word_nxt,
  output logic [SW-1:0]                        o_slot,
  output logic                                 o_last
);
  logic [NIBBLES_PER_WORD-1:0][SYMBOL_W-1:0] r_shadow, w_nxt;
  logic [SW-1:0]                             r_slot, w_pos;

  // Only meaningful while r_slot < NIBBLES_PER_WORD, i.e. whenever i_wr can fire.
  assign w_pos = MSN_FIRST ? (SW'(NIBBLES_PER_WORD - 1) - r_slot) : r_slot;

  for (genvar g = 0; g < NIBBLES_PER_WORD; g++) begin : g_slot
    assign w_nxt[g] = (w_pos == SW'(g)) ? i_nib : r_shadow[g];
  end

  assign o_word     = r_shadow;
  assign o_word_nxt = w_nxt;
  assign o_slot     = r_slot;
  assign o_last     = (r_slot == SW'(NIBBLES_PER_WORD - 1));

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_slot   <= '0;
    end else if (i_clr) begin
      r_shadow <= '0;
      r_slot   <= '0;
    end else if (i_wr) begin
      r_shadow <= w_nxt;
      r_slot   <= r_slot + 1'b1;
    end
  end
endmodule

// File: rtl/qam_nibble_packer.sv
// Pops 4-bit symbols from a non-show-ahead FIFO and packs them into words on a
// valid/ready bus; flush emits a zero-padded partial word. Option: QAM_PACKER_PARITY_EN.
module qam_nibble_packer
  import qam_pkg::*;
#(
  parameter int NIBBLES_PER_WORD = 2,
  parameter bit MSN_FIRST        = 1'b1
) (
  input  logic            dclk,
  input  logic            reset,
  input  logic            enable,
  input  logic            flush,
  output logic [WC_W-1:0] word_count,
  qam_nibble_packer_if.master bus
);
  localparam int OW = SYMBOL_W * NIBBLES_PER_WORD;
  localparam int SW = $clog2(NIBBLES_PER_WORD + 1);

  logic [1:0]      r_state;
  logic [OW-1:0]   r_out_data;
  logic            r_out_partial;
  logic [WC_W-1:0] r_word_count;
  logic            w_rd, w_acc, w_flush_go, w_last;
  logic [OW-1:0]   w_word, w_word_nxt, w_emit_val;
  logic [SW-1:0]   w_slot;

  // Read only from FETCH and never on empty, so the FIFO cannot underflow.
  assign w_rd       = (r_state == FETCH) && enable && !bus.rdempty;
  assign w_flush_go = (r_state == FETCH) && !w_rd && flush && (w_slot != '0);
  assign w_acc      = (r_state == EMIT) && bus.out_ready;
  assign w_emit_val = (r_state == LATCH) ? w_word_nxt : w_word;

  qam_nibble_shift_slot #(
    .NIBBLES_PER_WORD(NIBBLES_PER_WORD),
    .MSN_FIRST       (MSN_FIRST)
  ) u_slot (
    .dclk      (dclk),
    .reset     (reset),
    .i_wr      (r_state == LATCH),
    .i_clr     (w_acc),
    .i_nib     (bus.q),
    .o_word    (w_word),
    .o_word_nxt(w_word_nxt),
    .o_slot    (w_slot),
    .o_last    (w_last)
  );

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_out_data    <= '0;
      r_out_partial <= 1'b0;
      r_word_count  <= '0;
    end else begin
      case (r_state)
        IDLE:  if (enable) r_state <= FETCH;
        FETCH: begin
          if (w_rd) begin
            r_state <= LATCH;
          end else if (w_flush_go) begin
            r_state       <= EMIT;
            r_out_data    <= w_emit_val;
            r_out_partial <= 1'b1;
          end else if (!enable && (w_slot == '0)) begin
            r_state <= IDLE;
          end
        end
        LATCH: begin
          if (w_last) begin
            r_state       <= EMIT;
            r_out_data    <= w_emit_val;
            r_out_partial <= 1'b0;
          end else begin
            r_state <= FETCH;
          end
        end
        default: begin
          if (w_acc) begin
            r_state      <= FETCH;
            r_word_count <= r_word_count + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef QAM_PACKER_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge dclk or posedge reset) begin
    if (reset)
      r_out_parity <= 1'b0;
    else if (w_flush_go || ((r_state == LATCH) && w_last))
      r_out_parity <= ^w_emit_val;
  end

  assign bus.out_parity = r_out_parity;
`endif

  assign bus.rdreq       = w_rd;
  assign bus.out_valid   = (r_state == EMIT);
  assign bus.out_data    = r_out_data;
  assign bus.out_partial = r_out_partial;
  assign word_count      = r_word_count;
endmodule

// File: doc/qam_nibble_packer.md
Name: qam_nibble_packer

Overview:
- Downstream consumer of the 16QAM demapper's output FIFO, in the dclk domain.
- Pops 4-bit demapped symbols from the FIFO read side and packs NIBBLES_PER_WORD of them into one output word.
- Presents each word on a valid/ready handshake to the next stage (byte sink / UART / framer).
- Provides a flush path that emits a zero-padded partial word at end of burst.

Parameters:
- NIBBLES_PER_WORD, 2, symbols per output word; legal range 2..8. Output width is 4*NIBBLES_PER_WORD.
- MSN_FIRST, 1, 1 = first popped nibble lands in the most-significant slot; 0 = least-significant slot.

Ports:
- dclk  in  1  data clock; same clock as the FIFO read side.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = packing allowed; 0 = no new FIFO reads.
- rdempty  in  1  FIFO empty flag.
- q  in  4  FIFO read data; valid the cycle after rdreq (non-show-ahead).
- rdreq  out  1  FIFO read request; single-cycle pulse.
- flush  in  1  request to emit the current partial word.
- out_data  out  4*NIBBLES_PER_WORD  packed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word when out_valid && out_ready.
- out_partial  out  1  word was flushed before it was full; qualified by out_valid.
- word_count  out  16  count of accepted words; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, immediate): state=IDLE; rdreq=0; out_valid=0; out_partial=0; out_data=0; slot counter=0; word_count=0.
- Reset asserted mid-operation discards any partial word. A FIFO read in flight is lost; the system resets the FIFO with the same reset.
- FSM states: IDLE, FETCH, LATCH, EMIT.
- IDLE -> FETCH when enable=1.
- FETCH:
  - If enable && !rdempty: drive rdreq=1 for this cycle only, go to LATCH.
  - Else if flush && slot>0: go to EMIT with out_partial=1.
  - Else if !enable && slot==0: go to IDLE.
  - Otherwise stay in FETCH.
- LATCH:
  - Capture q into slot position (slot index if MSN_FIRST=0; NIBBLES_PER_WORD-1-slot if MSN_FIRST=1). Increment slot.
  - If slot reaches NIBBLES_PER_WORD: go to EMIT with out_partial=0. Else go to FETCH.
- Unfilled slots are always 0. The shadow register is cleared after every accepted word.
- EMIT:
  - out_valid=1. out_data and out_partial are registered and held stable until the handshake.
  - On out_valid && out_ready: clear slot and shadow, increment word_count, go to FETCH.
  - No rdreq is issued while in EMIT (backpressure reaches the FIFO).
- Latency: rdreq at cycle t; q captured at end of t+1; out_valid asserted at t+2 after the last nibble.
- Throughput: one nibble per 2 dclk cycles, adequate because sclk << dclk.
- Flush is ignored when slot==0. Flush while in LATCH is sampled on the next FETCH cycle. If flush and !rdempty coincide in FETCH, the read wins and flush is re-evaluated on the next FETCH.
- rdreq is never asserted while rdempty=1, so the FIFO never underflows.
- Dropping enable mid-word: the block finishes the pending LATCH, then parks in FETCH holding the partial word (no data lost) until enable returns or flush is asserted.

Optional Feature:
- Macro: QAM_PACKER_PARITY_EN.
- Defined: adds output out_parity (1 bit) = even parity (XOR) over out_data, registered with out_data and valid with out_valid.
- Undefined: port absent, no parity logic. All other behaviour identical.

Decomposition:
- Shared package qam_pkg holds:
  - SYMBOL_W = 4.
  - State encoding constants IDLE=2'd0, FETCH=2'd1, LATCH=2'd2, EMIT=2'd3.
  - Word-count width constant = 16.
- One sub-module is natural: qam_nibble_shift_slot, the slot register with indexed write and clear, parameterised by NIBBLES_PER_WORD and MSN_FIRST.
- FSM and handshake stay in the top module.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; word_count=0; no rdreq for the whole reset period.
- Basic pack (defaults): FIFO holds 0xA, 0x5; enable=1; out_ready=1 -> rdreq pulses twice, 2 cycles apart; out_data=0xA5; out_partial=0; word_count=1. With MSN_FIRST=0 -> out_data=0x5A.
- Backpressure: 4 nibbles queued, out_ready=0 for 6 cycles -> out_data stays 0xA5 and out_valid=1 for 6 cycles; rdreq=0 throughout; second word follows after the handshake.
- Underflow guard: rdempty=1 for 10 cycles with enable=1 -> rdreq never asserted; nibble 0x3 then arrives -> read and captured; state returns to FETCH.
- Flush: one nibble 0x3 read, then rdempty=1 and flush=1 -> out_data=0x30, out_partial=1; next full word has out_partial=0.
- Parity (macro defined) and word_count wrap: word 0xA5 -> out_parity=0; word 0xA4 -> out_parity=1. Preload to 0xFFFF, accept one word -> word_count=0x0000.
